timing_generator: RTL and testbench

TIMING_GENERATOR -- requirements
Module: timing_generator

---
 rtl/cpu6502_pkg.sv | 43 ++++
 rtl/timing_generator_if.sv | 40 ++++
 rtl/timing_generator_neg_edge_detect.sv | 28 ++
 rtl/timing_generator.sv | 147 ++++++++++++++
 tb/tb_timing_generator.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu6502_pkg.sv
// ----------------------------------------------------------------------------
// cpu6502_pkg
// Shared types and constants for the 6502 timing generator slice.
//   state_e      : sequencer states (RESET_SEQ, RUN, INT_SEQ)
//   vector_sel_e : vector select encoding driven on VECTOR_SEL
//   VEC_*        : vector addresses selected by vector_sel_e
//   T_MAX        : last legal T-state of any sequence
// ----------------------------------------------------------------------------
package cpu6502_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        RUN       = 2'd1,
        INT_SEQ   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        VSEL_IRQ   = 2'd0,
        VSEL_NMI   = 2'd1,
        VSEL_RESET = 2'd2
    } vector_sel_e;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    localparam logic [2:0] T_MAX         = 3'd6;
    // Last INT_SEQ T-state at which a new NMI edge may still redirect the vector
    localparam logic [2:0] T_HIJACK_LAST = 3'd4;
    // INT_SEQ T-state at which a serviced NMI is retired
    localparam logic [2:0] T_NMI_CLEAR   = 3'd5;

    function automatic logic [15:0] vector_addr(input vector_sel_e sel);
        logic [15:0] addr;
        case (sel)
            VSEL_NMI:   addr = VEC_NMI;
            VSEL_RESET: addr = VEC_RESET;
            default:    addr = VEC_IRQ;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/timing_generator_if.sv
// ----------------------------------------------------------------------------
// timing_generator_if
// Core <-> timing generator signal bundle.
//   master modport : core side, drives RDY/IRQ/NMI/SO/RW/I_FLAG/T_LAST
//   slave modport  : timing generator, drives T_STATE/SYNC/IR_LOAD/FORCE_BRK/
//                    PC_INC_INH/WRITE_SUPPRESS/VECTOR_SEL/STALL/SO_SET
// ----------------------------------------------------------------------------
interface timing_generator_if;

    logic       RDY;
    logic       IRQ;
    logic       NMI;
    logic       SO;
    logic       RW;
    logic       I_FLAG;
    logic       T_LAST;

    logic [2:0] T_STATE;
    logic       SYNC;
    logic       IR_LOAD;
    logic       FORCE_BRK;
    logic       PC_INC_INH;
    logic       WRITE_SUPPRESS;
    logic [1:0] VECTOR_SEL;
    logic       STALL;
    logic       SO_SET;

    modport master (
        output RDY, IRQ, NMI, SO, RW, I_FLAG, T_LAST,
        input  T_STATE, SYNC, IR_LOAD, FORCE_BRK, PC_INC_INH,
               WRITE_SUPPRESS, VECTOR_SEL, STALL, SO_SET
    );

    modport slave (
        input  RDY, IRQ, NMI, SO, RW, I_FLAG, T_LAST,
        output T_STATE, SYNC, IR_LOAD, FORCE_BRK, PC_INC_INH,
               WRITE_SUPPRESS, VECTOR_SEL, STALL, SO_SET
    );

endinterface

// File: rtl/timing_generator_neg_edge_detect.sv
// ----------------------------------------------------------------------------
// neg_edge_detect
// One-bit falling-edge detector against a registered history bit.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset (history reset to 1)
//   i_d     : sampled input
//   o_fall  : one-cycle pulse while history=1 and input=0
// ----------------------------------------------------------------------------
module neg_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_fall = r_prev & ~i_d;

endmodule

// File: rtl/timing_generator.sv
// ----------------------------------------------------------------------------
// timing_generator
// 6502-style T-state sequencer: reset sequence, instruction cycle counting,
// interrupt entry (forced BRK), NMI hijack and RDY stall handling.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : timing_generator_if.slave (core inputs, timing outputs)
// Optional feature: define TINYMOS_SO_PIN_EN to enable the SO pin edge
// detector driving SO_SET; otherwise SO is ignored and SO_SET is 0.
// ----------------------------------------------------------------------------
module timing_generator
    import cpu6502_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    timing_generator_if.slave bus
);

    state_e      r_state;
    logic [2:0]  r_t;
    logic        r_nmi_pending;
    logic        r_vec_nmi;

    logic        w_stall;
    logic        w_nmi_fall;
    logic        w_nmi_req;
    logic        w_int_pending;
    logic        w_fetch;
    vector_sel_e w_vsel;

    neg_edge_detect u_nmi_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (bus.NMI),
        .o_fall  (w_nmi_fall)
    );

    assign w_stall       = ~bus.RDY & bus.RW;
    // A fresh edge counts as pending in the same cycle it is seen
    assign w_nmi_req     = r_nmi_pending | w_nmi_fall;
    assign w_int_pending = w_nmi_req | (~bus.IRQ & ~bus.I_FLAG);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= RESET_SEQ;
            r_t           <= '0;
            r_nmi_pending <= 1'b0;
            r_vec_nmi     <= 1'b0;
        end else begin
            // Edge capture runs even while stalled; a new edge beats the retire
            if (w_nmi_fall) begin
                r_nmi_pending <= 1'b1;
            end else if (!w_stall && r_state == INT_SEQ && r_t == T_NMI_CLEAR && r_vec_nmi) begin
                r_nmi_pending <= 1'b0;
            end

            if (!w_stall) begin
                case (r_state)
                    RESET_SEQ: begin
                        if (r_t == T_MAX) begin
                            r_state <= RUN;
                            r_t     <= '0;
                        end else begin
                            r_t <= r_t + 3'd1;
                        end
                    end
                    RUN: begin
                        if (bus.T_LAST) begin
                            r_t <= '0;
                            if (w_int_pending) begin
                                r_state   <= INT_SEQ;
                                r_vec_nmi <= w_nmi_req;
                            end
                        end else if (r_t == T_MAX) begin
                            r_t <= '0;
                        end else begin
                            r_t <= r_t + 3'd1;
                        end
                    end
                    INT_SEQ: begin
                        if (r_t == T_MAX) begin
                            r_state   <= RUN;
                            r_t       <= '0;
                            r_vec_nmi <= 1'b0;
                        end else begin
                            r_t <= r_t + 3'd1;
                            if (r_t <= T_HIJACK_LAST && w_nmi_req) begin
                                r_vec_nmi <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= RESET_SEQ;
                        r_t     <= '0;
                    end
                endcase
            end
        end
    end

    // INT_SEQ/T0 is the forced-BRK opcode fetch, so it is a SYNC cycle too
    assign w_fetch = (r_t == 3'd0) && (r_state == RUN || r_state == INT_SEQ);

    always_comb begin
        w_vsel = VSEL_IRQ;
        case (r_state)
            RESET_SEQ: w_vsel = VSEL_RESET;
            INT_SEQ:   w_vsel = r_vec_nmi ? VSEL_NMI : VSEL_IRQ;
            default:   w_vsel = VSEL_IRQ;
        endcase
    end

    assign bus.T_STATE        = r_t;
    assign bus.STALL          = w_stall;
    assign bus.SYNC           = w_fetch & ~w_stall;
    assign bus.IR_LOAD        = w_fetch & ~w_stall;
    assign bus.FORCE_BRK      = (r_state == INT_SEQ) && (r_t == 3'd0);
    assign bus.PC_INC_INH     = (r_state == INT_SEQ) && (r_t == 3'd0);
    assign bus.WRITE_SUPPRESS = (r_state == RESET_SEQ);
    assign bus.VECTOR_SEL     = w_vsel;

`ifdef TINYMOS_SO_PIN_EN
    logic w_so_fall;
    logic r_so_set;

    neg_edge_detect u_so_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (bus.SO),
        .o_fall  (w_so_fall)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_so_set <= 1'b0;
        end else begin
            r_so_set <= w_so_fall;
        end
    end

    assign bus.SO_SET = r_so_set;
`else
    logic w_unused_so;
    assign w_unused_so = bus.SO;
    assign bus.SO_SET  = 1'b0;
`endif

endmodule

// File: tb/tb_timing_generator.sv
// ----------------------------------------------------------------------------
// tb_timing_generator
// Directed self-checking bench for timing_generator. Honours
// TINYMOS_SO_PIN_EN for the SO_SET expectation.
// ----------------------------------------------------------------------------
module tb_timing_generator;

    logic CLK;
    logic RST_N;
    int   total;
    int   bad;

`ifdef TINYMOS_SO_PIN_EN
    localparam logic EXP_SO_PULSE = 1'b1;
`else
    localparam logic EXP_SO_PULSE = 1'b0;
`endif

    timing_generator_if bus ();

    timing_generator dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_defaults();
        bus.RDY    = 1'b1;
        bus.IRQ    = 1'b1;
        bus.NMI    = 1'b1;
        bus.SO     = 1'b1;
        bus.RW     = 1'b1;
        bus.I_FLAG = 1'b1;
        bus.T_LAST = 1'b0;
    endtask

    // Brings the DUT to RUN/T0 with idle inputs
    task automatic do_reset();
        set_defaults();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        repeat (7) step();
    endtask

    task automatic test_reset();
        set_defaults();
        RST_N = 1'b0;
        step();
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL rst_t: got %0d want 0", bus.T_STATE); end
        total++; if (bus.SYNC !== 1'b0) begin bad++; $display("FAIL rst_sync: got %0b want 0", bus.SYNC); end
        total++; if (bus.IR_LOAD !== 1'b0) begin bad++; $display("FAIL rst_irload: got %0b want 0", bus.IR_LOAD); end
        total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL rst_brk: got %0b want 0", bus.FORCE_BRK); end
        total++; if (bus.PC_INC_INH !== 1'b0) begin bad++; $display("FAIL rst_pcinh: got %0b want 0", bus.PC_INC_INH); end
        total++; if (bus.WRITE_SUPPRESS !== 1'b1) begin bad++; $display("FAIL rst_ws: got %0b want 1", bus.WRITE_SUPPRESS); end
        total++; if (bus.VECTOR_SEL !== 2'd2) begin bad++; $display("FAIL rst_vsel: got %0d want 2", bus.VECTOR_SEL); end
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", bus.STALL); end
        total++; if (bus.SO_SET !== 1'b0) begin bad++; $display("FAIL rst_soset: got %0b want 0", bus.SO_SET); end
        RST_N = 1'b1;
        #1;
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL rel_t: got %0d want 0", bus.T_STATE); end
        total++; if (bus.WRITE_SUPPRESS !== 1'b1) begin bad++; $display("FAIL rel_ws: got %0b want 1", bus.WRITE_SUPPRESS); end
        for (int i = 1; i <= 6; i++) begin
            step();
            total++; if (bus.T_STATE !== 3'(i)) begin bad++; $display("FAIL rseq_t: got %0d want %0d", bus.T_STATE, i); end
            total++; if (bus.WRITE_SUPPRESS !== 1'b1) begin bad++; $display("FAIL rseq_ws: t=%0d got %0b want 1", i, bus.WRITE_SUPPRESS); end
            total++; if (bus.VECTOR_SEL !== 2'd2) begin bad++; $display("FAIL rseq_vsel: t=%0d got %0d want 2", i, bus.VECTOR_SEL); end
            total++; if (bus.SYNC !== 1'b0) begin bad++; $display("FAIL rseq_sync: t=%0d got %0b want 0", i, bus.SYNC); end
        end
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL run0_t: got %0d want 0", bus.T_STATE); end
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL run0_sync: got %0b want 1", bus.SYNC); end
        total++; if (bus.IR_LOAD !== 1'b1) begin bad++; $display("FAIL run0_irload: got %0b want 1", bus.IR_LOAD); end
        total++; if (bus.WRITE_SUPPRESS !== 1'b0) begin bad++; $display("FAIL run0_ws: got %0b want 0", bus.WRITE_SUPPRESS); end
    endtask

    task automatic test_normal_run();
        int exp_t [4] = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.T_STATE !== 3'(exp_t[i])) begin bad++; $display("FAIL run_t: step %0d got %0d want %0d", i, bus.T_STATE, exp_t[i]); end
            total++; if (bus.SYNC !== (exp_t[i] == 0)) begin bad++; $display("FAIL run_sync: step %0d got %0b want %0b", i, bus.SYNC, exp_t[i] == 0); end
            total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL run_brk: step %0d got %0b want 0", i, bus.FORCE_BRK); end
            bus.T_LAST = (exp_t[i] == 2);
            step();
        end
        bus.T_LAST = 1'b0;
    endtask

    task automatic test_forced_wrap();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            total++; if (bus.T_STATE !== 3'(i)) begin bad++; $display("FAIL wrap_t: got %0d want %0d", bus.T_STATE, i); end
        end
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL wrap_t0: got %0d want 0", bus.T_STATE); end
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL wrap_sync: got %0b want 1", bus.SYNC); end
    endtask

    task automatic test_irq();
        do_reset();
        bus.I_FLAG = 1'b0;
        bus.IRQ    = 1'b0;
        step();
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL irq_t0: got %0d want 0", bus.T_STATE); end
        total++; if (bus.FORCE_BRK !== 1'b1) begin bad++; $display("FAIL irq_brk: got %0b want 1", bus.FORCE_BRK); end
        total++; if (bus.PC_INC_INH !== 1'b1) begin bad++; $display("FAIL irq_pcinh: got %0b want 1", bus.PC_INC_INH); end
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL irq_sync: got %0b want 1", bus.SYNC); end
        total++; if (bus.VECTOR_SEL !== 2'd0) begin bad++; $display("FAIL irq_vsel0: got %0d want 0", bus.VECTOR_SEL); end
        bus.IRQ    = 1'b1;
        bus.I_FLAG = 1'b1;
        bus.T_LAST = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            total++; if (bus.T_STATE !== 3'(i)) begin bad++; $display("FAIL irqseq_t: got %0d want %0d", bus.T_STATE, i); end
            total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL irqseq_brk: t=%0d got %0b want 0", i, bus.FORCE_BRK); end
            total++; if (bus.VECTOR_SEL !== 2'd0) begin bad++; $display("FAIL irqseq_vsel: t=%0d got %0d want 0", i, bus.VECTOR_SEL); end
            total++; if (bus.SYNC !== 1'b0) begin bad++; $display("FAIL irqseq_sync: t=%0d got %0b want 0", i, bus.SYNC); end
        end
        step();
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL irqend_sync: got %0b want 1", bus.SYNC); end
        total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL irqend_brk: got %0b want 0", bus.FORCE_BRK); end
        // Masked IRQ: I_FLAG=1
        bus.IRQ    = 1'b0;
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL irqmask_brk: got %0b want 0", bus.FORCE_BRK); end
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL irqmask_t: got %0d want 0", bus.T_STATE); end
        bus.IRQ    = 1'b1;
        bus.T_LAST = 1'b0;
    endtask

    task automatic test_nmi_hijack();
        do_reset();
        bus.I_FLAG = 1'b0;
        bus.IRQ    = 1'b0;
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.FORCE_BRK !== 1'b1) begin bad++; $display("FAIL hij_brk: got %0b want 1", bus.FORCE_BRK); end
        bus.IRQ    = 1'b1;
        bus.I_FLAG = 1'b1;
        bus.T_LAST = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (bus.VECTOR_SEL !== 2'd0) begin bad++; $display("FAIL hij_pre_vsel: t=%0d got %0d want 0", i, bus.VECTOR_SEL); end
        end
        bus.NMI = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            step();
            total++; if (bus.T_STATE !== 3'(i)) begin bad++; $display("FAIL hij_t: got %0d want %0d", bus.T_STATE, i); end
            total++; if (bus.VECTOR_SEL !== 2'd1) begin bad++; $display("FAIL hij_vsel: t=%0d got %0d want 1", i, bus.VECTOR_SEL); end
        end
        step();
        total++; if (bus.VECTOR_SEL !== 2'd0) begin bad++; $display("FAIL hij_end_vsel: got %0d want 0", bus.VECTOR_SEL); end
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL hij_end_sync: got %0b want 1", bus.SYNC); end
        // NMI still low: no retrigger, pending already retired
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL nmi_noretrig: got %0b want 0", bus.FORCE_BRK); end
        // Fresh NMI edge together with unmasked IRQ: NMI vector wins
        bus.T_LAST = 1'b0;
        bus.NMI    = 1'b1;
        step();
        bus.NMI    = 1'b0;
        bus.IRQ    = 1'b0;
        bus.I_FLAG = 1'b0;
        step();
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.FORCE_BRK !== 1'b1) begin bad++; $display("FAIL nmi_brk: got %0b want 1", bus.FORCE_BRK); end
        total++; if (bus.VECTOR_SEL !== 2'd1) begin bad++; $display("FAIL nmi_prio_vsel: got %0d want 1", bus.VECTOR_SEL); end
        set_defaults();
    endtask

    task automatic test_stall();
        do_reset();
        step();
        bus.RDY = 1'b0;
        #1;
        total++; if (bus.STALL !== 1'b1) begin bad++; $display("FAIL stall_on: got %0b want 1", bus.STALL); end
        total++; if (bus.T_STATE !== 3'd1) begin bad++; $display("FAIL stall_t0: got %0d want 1", bus.T_STATE); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (bus.T_STATE !== 3'd1) begin bad++; $display("FAIL stall_hold: cyc %0d got %0d want 1", i, bus.T_STATE); end
            total++; if (bus.STALL !== 1'b1) begin bad++; $display("FAIL stall_held: cyc %0d got %0b want 1", i, bus.STALL); end
        end
        bus.RDY = 1'b1;
        #1;
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL stall_off: got %0b want 0", bus.STALL); end
        step();
        total++; if (bus.T_STATE !== 3'd2) begin bad++; $display("FAIL stall_resume: got %0d want 2", bus.T_STATE); end
        bus.RW  = 1'b0;
        bus.RDY = 1'b0;
        #1;
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL write_nostall: got %0b want 0", bus.STALL); end
        step();
        total++; if (bus.T_STATE !== 3'd3) begin bad++; $display("FAIL write_adv: got %0d want 3", bus.T_STATE); end
        bus.RW     = 1'b1;
        bus.RDY    = 1'b1;
        bus.T_LAST = 1'b1;
        step();
        bus.T_LAST = 1'b0;
        bus.RDY    = 1'b0;
        #1;
        total++; if (bus.SYNC !== 1'b0) begin bad++; $display("FAIL stall_sync: got %0b want 0", bus.SYNC); end
        total++; if (bus.IR_LOAD !== 1'b0) begin bad++; $display("FAIL stall_irload: got %0b want 0", bus.IR_LOAD); end
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL stall_t0hold: got %0d want 0", bus.T_STATE); end
        bus.RDY = 1'b1;
        #1;
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL stall_sync_back: got %0b want 1", bus.SYNC); end
        step();
        total++; if (bus.T_STATE !== 3'd1) begin bad++; $display("FAIL stall_t1: got %0d want 1", bus.T_STATE); end
    endtask

    task automatic test_so();
        do_reset();
        step();
        bus.SO = 1'b0;
        #1;
        total++; if (bus.SO_SET !== 1'b0) begin bad++; $display("FAIL so_early: got %0b want 0", bus.SO_SET); end
        step();
        total++; if (bus.SO_SET !== EXP_SO_PULSE) begin bad++; $display("FAIL so_pulse: got %0b want %0b", bus.SO_SET, EXP_SO_PULSE); end
        step();
        total++; if (bus.SO_SET !== 1'b0) begin bad++; $display("FAIL so_once: got %0b want 0", bus.SO_SET); end
        // Same edge while stalled
        bus.SO  = 1'b1;
        bus.RDY = 1'b0;
        step();
        bus.SO = 1'b0;
        step();
        total++; if (bus.SO_SET !== EXP_SO_PULSE) begin bad++; $display("FAIL so_stall_pulse: got %0b want %0b", bus.SO_SET, EXP_SO_PULSE); end
        step();
        total++; if (bus.SO_SET !== 1'b0) begin bad++; $display("FAIL so_stall_once: got %0b want 0", bus.SO_SET); end
        set_defaults();
    endtask

    task automatic test_reset_abort();
        do_reset();
        bus.NMI = 1'b0;
        step();
        RST_N = 1'b0;
        step();
        total++; if (bus.T_STATE !== 3'd0) begin bad++; $display("FAIL abort_t: got %0d want 0", bus.T_STATE); end
        total++; if (bus.VECTOR_SEL !== 2'd2) begin bad++; $display("FAIL abort_vsel: got %0d want 2", bus.VECTOR_SEL); end
        bus.NMI = 1'b1;
        step();
        RST_N = 1'b1;
        repeat (7) step();
        bus.T_LAST = 1'b1;
        step();
        total++; if (bus.FORCE_BRK !== 1'b0) begin bad++; $display("FAIL abort_nopend: got %0b want 0", bus.FORCE_BRK); end
        total++; if (bus.SYNC !== 1'b1) begin bad++; $display("FAIL abort_sync: got %0b want 1", bus.SYNC); end
        bus.T_LAST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        set_defaults();
        test_reset();
        test_normal_run();
        test_forced_wrap();
        test_irq();
        test_nmi_hijack();
        test_stall();
        test_so();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
